// File: rtl/instr_cache.sv
// instr_cache: direct-mapped instruction cache, one 32-bit word per line,
// with a single outstanding backing-memory read and flush cancellation.
module instr_cache #(
   parameter int INDEX_BITS = 7
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic [31:0] cpu_addr,
   input  logic        cpu_flush,
   output logic        cpu_ready,
   output logic        cpu_valid,
   output logic [31:0] cpu_q,
   input  logic        inval,
   output logic        mem_start,
   output logic [31:0] mem_addr,
   input  logic        mem_done,
   input  logic [31:0] mem_q
);

   localparam int LINES    = 1 << INDEX_BITS;
   localparam int TAG_BITS = 30 - INDEX_BITS;

   typedef enum logic [1:0] {IDLE, LOOKUP, MISS_WAIT} state_t;

   state_t                state_q, state_d;
   logic [29:0]           lookup_addr_q, lookup_addr_d;
   logic [LINES-1:0]      valid_q, valid_d;
   logic                  cancel_q, cancel_d;
   logic                  inval_pend_q, inval_pend_d;
   logic [31:0]           held_q, held_d;
   logic [TAG_BITS-1:0]   tag_q [LINES];
   logic [31:0]           data_q [LINES];

   logic [INDEX_BITS-1:0] lookup_idx;
   logic [TAG_BITS-1:0]   lookup_tag;
   logic                  hit;
   logic                  inval_req;
   logic                  fill_we;
   logic                  unused_addr_bits;

   // The lookup address is kept as a word address; byte-offset bits never matter.
   assign lookup_idx       = lookup_addr_q[INDEX_BITS-1:0];
   assign lookup_tag       = lookup_addr_q[29:INDEX_BITS];
   assign hit              = valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag);
   assign inval_req        = inval || inval_pend_q;
   assign mem_addr         = {lookup_addr_q, 2'b00};
   assign unused_addr_bits = ^cpu_addr[1:0];

   // Next-state, handshake and response logic for the IDLE/LOOKUP/MISS_WAIT flow.
   always_comb begin
      state_d       = state_q;
      lookup_addr_d = lookup_addr_q;
      valid_d       = valid_q;
      cancel_d      = cancel_q;
      inval_pend_d  = inval_pend_q || inval;
      held_d        = held_q;
      cpu_ready     = 1'b0;
      cpu_valid     = 1'b0;
      cpu_q         = held_q;
      mem_start     = 1'b0;
      fill_we       = 1'b0;

      unique case (state_q)
         IDLE: begin
            cpu_ready = !inval_req;
            if (cpu_req && cpu_ready) begin
               lookup_addr_d = cpu_addr[31:2];
               state_d       = LOOKUP;
            end else if (inval_req) begin
               valid_d      = '0;
               inval_pend_d = 1'b0;
            end
         end
         LOOKUP: begin
            cpu_ready = hit || cpu_flush;
            if (!cpu_flush && hit) begin
               cpu_valid = 1'b1;
               cpu_q     = data_q[lookup_idx];
               held_d    = data_q[lookup_idx];
            end
            if (cpu_req && cpu_ready) begin
               lookup_addr_d = cpu_addr[31:2];
               state_d       = LOOKUP;
            end else if (cpu_flush || hit) begin
               state_d = IDLE;
            end else begin
               mem_start = 1'b1;
               state_d   = MISS_WAIT;
            end
         end
         MISS_WAIT: begin
            if (cpu_flush) begin
               cancel_d = 1'b1;
            end
            if (mem_done) begin
               fill_we             = 1'b1;
               valid_d[lookup_idx] = 1'b1;
               if (!cancel_q && !cpu_flush) begin
                  cpu_valid = 1'b1;
                  cpu_q     = mem_q;
                  held_d    = mem_q;
               end
               cancel_d = 1'b0;
               state_d  = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Control state, valid bits and the held instruction word.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         lookup_addr_q <= '0;
         valid_q       <= '0;
         cancel_q      <= 1'b0;
         inval_pend_q  <= 1'b0;
         held_q        <= '0;
      end else begin
         state_q       <= state_d;
         lookup_addr_q <= lookup_addr_d;
         valid_q       <= valid_d;
         cancel_q      <= cancel_d;
         inval_pend_q  <= inval_pend_d;
         held_q        <= held_d;
      end
   end

   // Tag and data storage is written only when a backing read returns.
   always_ff @(posedge clk) begin
      if (fill_we) begin
         tag_q[lookup_idx]  <= lookup_tag;
         data_q[lookup_idx] <= mem_q;
      end
   end

endmodule

// File: doc/instr_cache.md
INSTR_CACHE -- requirements
Module: instr_cache

Interface
REQ-001 Parameter INDEX_BITS, default 7, number of line-index bits; 2^INDEX_BITS lines of one 32-bit word each.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 cpu_req  input  1  fetch unit presents an address this cycle.
REQ-005 cpu_addr  input  32  byte address of instruction; bits [1:0] ignored.
REQ-006 cpu_flush  input  1  cancel any fetch accepted before this cycle (pipeline redirect).
REQ-007 cpu_ready  output  1  cache accepts cpu_req this cycle.
REQ-008 cpu_valid  output  1  cpu_q holds the instruction for the oldest uncancelled accepted request.
REQ-009 cpu_q  output  32  instruction word.
REQ-010 inval  input  1  invalidate all lines.
REQ-011 mem_start  output  1  one-cycle pulse starting a backing-memory read.
REQ-012 mem_addr  output  32  word-aligned read address; stable from mem_start until mem_done.
REQ-013 mem_done  input  1  one-cycle pulse; mem_q valid this cycle; latency unbounded, at least 1 cycle after mem_start.
REQ-014 mem_q  input  32  read data from backing memory.

Function
REQ-015 Direct-mapped: index = cpu_addr[INDEX_BITS+1:2]; tag = cpu_addr[31:INDEX_BITS+2]; per-line valid bit, tag, data word.
REQ-016 Request is accepted when cpu_req && cpu_ready at a rising edge; address registered internally as the lookup address.
REQ-017 States: IDLE, LOOKUP, MISS_WAIT.
REQ-018 IDLE: cpu_ready=1; on accept -> LOOKUP; on inval without accept -> clear all valid bits, stay IDLE.
REQ-019 LOOKUP, hit (valid && tag match): cpu_valid=1, cpu_q=line data, cpu_ready=1 combinationally; new accept stays in LOOKUP, else -> IDLE. Hit latency 1 cycle; back-to-back hits sustain 1 fetch/cycle.
REQ-020 LOOKUP, miss: cpu_valid=0, cpu_ready=0, mem_start=1, mem_addr={lookup address[31:2],2'b00}; -> MISS_WAIT.
REQ-021 MISS_WAIT: cpu_ready=0; on mem_done write mem_q, tag, valid=1 into the line; cpu_valid=1 and cpu_q=mem_q in that same cycle unless cancelled; -> IDLE.
REQ-022 cpu_flush in LOOKUP: cpu_valid forced 0 that cycle; hit or miss, no mem_start issued for the cancelled request; -> IDLE, unless cpu_req is also accepted that cycle (new request survives the flush) -> LOOKUP.
REQ-023 cpu_flush in MISS_WAIT: request marked cancelled; memory read runs to completion and the line is still filled; cpu_valid stays 0 on mem_done; -> IDLE.
REQ-024 cpu_flush in IDLE: no effect.
REQ-025 inval is honored only in IDLE with no accept that cycle (cpu_ready forced 0 that cycle); in other states it is held pending and applied on the first IDLE cycle. A pending inval does not prevent the in-flight fill from completing.
REQ-026 Exactly one outstanding memory read; mem_start never asserted while in MISS_WAIT.
REQ-027 cpu_q holds its last value when cpu_valid=0; consumers ignore it.

Reset
REQ-028 On reset: state IDLE, all valid bits 0, cancel flag 0, pending inval 0, cpu_valid=0, cpu_q=0, mem_start=0, mem_addr=0; cpu_ready=1 from the first cycle after reset.
REQ-029 Reset during MISS_WAIT abandons the read; the backing memory is reset on the same reset, and mem_done arriving in IDLE is ignored.
REQ-030 Tag and data arrays are not reset; only the valid bits are.

Verification
REQ-031 Cold miss: after reset, req 0x00000010; mem_done 5 cycles after mem_start, mem_q=0xDEADBEEF -> mem_addr=0x10, cpu_valid=1 with cpu_q=0xDEADBEEF in the mem_done cycle; repeat 0x10 -> hit 1 cycle later, no mem_start.
REQ-032 Streaming hits: warm 0x0,0x4,0x8,0xC, then request them on 4 consecutive cycles -> 4 consecutive cpu_valid cycles, cpu_ready never low.
REQ-033 Conflict: with INDEX_BITS=7, fill 0x000, then req 0x200 (same index) -> miss and refill; req 0x000 -> miss again.
REQ-034 Flush mid-miss: req 0x40 misses, cpu_flush 2 cycles into MISS_WAIT, mem_done later -> no cpu_valid; a following req 0x40 hits.
REQ-035 Flush with new request: LOOKUP on a hit with cpu_flush and cpu_req 0x80 (warm) in the same cycle -> no cpu_valid that cycle; next cycle cpu_valid with data for 0x80.
REQ-036 Inval: warm 0x0, assert inval during a MISS_WAIT for 0x100 -> fill completes, then all lines invalid; req 0x0 and req 0x100 both miss.
